cla_wide_add_seq: RTL and testbench

//  Multi-cycle sequencer for wide adds on one shared SLICE-bit carry-lookahead slice.

---
 rtl/cla_wide_add_seq.sv | 141 ++++++++++++++
 tb/tb_cla_wide_add_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cla_wide_add_seq.sv
// cla_wide_add_seq: wide adder that reuses one SLICE-bit carry-lookahead slice.
// Operands are latched on accept, and the slice then works from LSB to MSB at one
// chunk per cycle. The carry between chunks is held in a register.
// Optional feature macro: ADDSUB_EN. When it is defined, the block has a `sub` port
// and subtracts a - b by latching ~b and forcing the carry-in to 1.
module cla_wide_add_seq #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_nextState;
    logic [CW-1:0]                r_cnt;
    logic                         r_carry;
    logic                         r_cout;
    logic [NSLICE-1:0][SLICE-1:0] r_a;
    logic [NSLICE-1:0][SLICE-1:0] r_b;
    logic [NSLICE-1:0][SLICE-1:0] r_sum;

    logic                         w_sub;
    logic [SLICE-1:0]             w_sliceA;
    logic [SLICE-1:0]             w_sliceB;
    logic [SLICE-1:0]             w_prop;
    logic [SLICE-1:0]             w_gen;
    logic [SLICE-1:0]             w_groupG;
    logic [SLICE-1:0]             w_groupP;
    logic [SLICE:0]               w_carry;
    logic [SLICE-1:0]             w_sliceSum;

`ifdef ADDSUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    // Lookahead slice for the current chunk. Prefix group generate/propagate terms let every bit carry come straight from the chunk carry-in.
    always_comb begin
        w_sliceA   = r_a[r_cnt];
        w_sliceB   = r_b[r_cnt];
        w_prop     = w_sliceA ^ w_sliceB;
        w_gen      = w_sliceA & w_sliceB;
        w_groupG   = '0;
        w_groupP   = '0;
        w_carry    = '0;
        w_groupG[0] = w_gen[0];
        w_groupP[0] = w_prop[0];
        for (int i = 1; i < SLICE; i++) begin
            w_groupG[i] = w_gen[i] | (w_prop[i] & w_groupG[i-1]);
            w_groupP[i] = w_prop[i] & w_groupP[i-1];
        end
        w_carry[0] = r_carry;
        for (int i = 0; i < SLICE; i++) begin
            w_carry[i+1] = w_groupG[i] | (w_groupP[i] & r_carry);
        end
        w_sliceSum = w_prop ^ w_carry[SLICE-1:0];
    end

    // State register. Reset drops any operation in flight and returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN stays for one cycle per chunk, and DONE waits for the consumer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_nextState = RUN;
            RUN:     if (r_cnt == LAST)  w_nextState = DONE;
            DONE:    if (out_ready)      w_nextState = IDLE;
            default:                     w_nextState = IDLE;
        endcase
    end

    // Datapath. It latches the operands on accept, writes back one sum chunk per RUN cycle, and holds the results in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_sub ? ~b : b;
                        r_carry <= w_sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_cnt] <= w_sliceSum;
                    r_carry      <= w_carry[SLICE];
                    if (r_cnt == LAST) begin
                        r_cout <= w_carry[SLICE];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed bench for cla_wide_add_seq with WIDTH=64 and SLICE=16, so one operation takes 4 RUN cycles.
module tb_cla_wide_add_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;

    int errors = 0;
    int checks = 0;

    cla_wide_add_seq #(.WIDTH(64), .SLICE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison, with an immediate assertion at the point of the check
    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation in IDLE and wait until out_valid is seen or the bound runs out.
    // Reports the latency in cycles and whether in_ready stayed low for the whole run.
    task automatic applyStimulus(input logic [63:0] ia, input logic [63:0] ib, input logic ic,
                                 input logic is, output int lat, output logic readyLow);
        @(negedge clk);
        a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
        checkOutput("in_ready_before_accept", {64'd0, in_ready}, 65'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ia; b = ~ib; cin = ~ic; sub = ~is;
        lat = 0;
        readyLow = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready) readyLow = 1'b0;
            @(negedge clk);
            lat++;
        end
        checkOutput("out_valid_timeout", {64'd0, out_valid}, 65'd1);
    endtask

    // Complete the result handshake and confirm the block is back in IDLE one cycle later
    task automatic finishOp(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_idle_ready"}, {64'd0, in_ready}, 65'd1);
        checkOutput({tag, "_idle_valid"}, {64'd0, out_valid}, 65'd0);
    endtask

    initial begin
        int          lat;
        logic        readyLow;
        logic [63:0] heldSum;
        logic        sawValid;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        checkOutput("reset_in_ready",  {64'd0, in_ready},  65'd1);
        checkOutput("reset_out_valid", {64'd0, out_valid}, 65'd0);
        checkOutput("reset_sum",       {1'b0, sum},        65'd0);
        checkOutput("reset_cout",      {64'd0, cout},      65'd0);

        // Carry ripples through all four slices
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, readyLow);
        checkOutput("ripple_latency", 65'(lat), 65'd4);
        checkOutput("ripple_sum",  {1'b0, sum},   65'd0);
        checkOutput("ripple_cout", {64'd0, cout}, 65'd1);
        finishOp("ripple");

        // Only the carry-in is set
        applyStimulus(64'd0, 64'd0, 1'b1, 1'b0, lat, readyLow);
        checkOutput("cin_latency",   65'(lat), 65'd4);
        checkOutput("cin_ready_low", {64'd0, readyLow}, 65'd1);
        checkOutput("cin_sum",  {1'b0, sum},   65'd1);
        checkOutput("cin_cout", {64'd0, cout}, 65'd0);
        finishOp("cin");

        // Backpressure: the result must be held for 5 cycles
        applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat, readyLow);
        checkOutput("bp_latency", 65'(lat), 65'd4);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_sum_held",  {1'b0, sum},        {1'b0, 64'h1234_5678_9ABC_DF00});
            checkOutput("bp_cout_held", {64'd0, cout},      65'd0);
            checkOutput("bp_valid",     {64'd0, out_valid}, 65'd1);
            @(negedge clk);
        end
        finishOp("bp");

        // Reset while IDLE holds a nonzero sum
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset2_sum",       {1'b0, sum},        65'd0);
        checkOutput("reset2_in_ready",  {64'd0, in_ready},  65'd1);
        checkOutput("reset2_out_valid", {64'd0, out_valid}, 65'd0);

        // Reset while RUN has cnt=2; that operation must never complete
        @(negedge clk);
        a = 64'hFFFF_0000_FFFF_0000; b = 64'h1234; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun_reset_idle",  {64'd0, in_ready},  65'd1);
        checkOutput("midrun_reset_valid", {64'd0, out_valid}, 65'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) sawValid = 1'b1;
            @(negedge clk);
        end
        checkOutput("midrun_no_valid", {64'd0, sawValid}, 65'd0);
        applyStimulus(64'd2, 64'd3, 1'b0, 1'b0, lat, readyLow);
        checkOutput("after_reset_sum",  {1'b0, sum},   65'd5);
        checkOutput("after_reset_cout", {64'd0, cout}, 65'd0);
        finishOp("after_reset");

        // Carry out of the top slice only
        applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0, lat, readyLow);
        checkOutput("msb_sum",  {1'b0, sum},   65'd2);
        checkOutput("msb_cout", {64'd0, cout}, 65'd1);
        heldSum = sum;
        finishOp("msb");
        checkOutput("msb_sum_after_handshake", {1'b0, sum}, {1'b0, heldSum});

`ifdef ADDSUB_EN
        // Subtraction yields a - b; cout=1 means no borrow
        applyStimulus(64'd5, 64'd7, 1'b0, 1'b1, lat, readyLow);
        checkOutput("sub_neg_sum",  {1'b0, sum},   {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        checkOutput("sub_neg_cout", {64'd0, cout}, 65'd0);
        finishOp("sub_neg");
        applyStimulus(64'd7, 64'd5, 1'b0, 1'b1, lat, readyLow);
        checkOutput("sub_pos_sum",  {1'b0, sum},   65'd2);
        checkOutput("sub_pos_cout", {64'd0, cout}, 65'd1);
        finishOp("sub_pos");
        for (int n = 0; n < 1000; n++) begin
            logic [63:0] ra, rb;
            logic        rc, rs;
            logic [64:0] expv;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            expv = rs ? ({1'b0, ra} + {1'b0, ~rb} + 65'd1)
                      : ({1'b0, ra} + {1'b0, rb} + {64'd0, rc});
            applyStimulus(ra, rb, rc, rs, lat, readyLow);
            checkOutput("random_result", {cout, sum}, expv);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
